// File: rtl/if_prefetch.sv
// if_prefetch: pipelined instruction-fetch front end.
// Issues fetch requests under a credit limit, tags returned instructions
// with their PC in a small FIFO, and supports redirect (flush + restart)
// by counting and discarding responses still owed for stale requests.
//
// Handshake semantics (all interfaces): a transfer happens on a rising
// clock edge where the valid-type signal and the ready-type signal are both
// high. Request side: inst_ena is valid, inst_ready is ready, and
// inst_addr is held stable while inst_ena is high and inst_ready is low.
// Response side has no back-pressure: inst_rvalid is always accepted.
// Decode side: out_valid is valid, out_ready is ready; out_valid comes
// only from registered FIFO state.
module if_prefetch #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h0000_0000_8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    output logic                  inst_ena,
    input  logic                  inst_ready,
    input  logic [INST_WIDTH-1:0] inst,
    input  logic                  inst_rvalid,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int CW1 = CW + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_INC    = ADDR_WIDTH'(INST_WIDTH / 8);
    localparam logic [CW:0]           DEPTH_LIM = CW1'(DEPTH);

    // Control state
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_resp_pc;
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_inflight;
    logic [CW-1:0]         r_drop_cnt;

    // FIFO storage (not reset; validity is carried by r_count)
    logic [INST_WIDTH-1:0] r_inst_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_pc_mem   [DEPTH];

    logic [CW:0]   w_credit_used;
    logic          w_issue;
    logic          w_resp;
    logic          w_drop;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_inflight_after_resp;

    // Every request in flight owns a FIFO slot, so a response can never
    // find the FIFO full.
    assign w_credit_used = {1'b0, r_count} + {1'b0, r_inflight};
    assign inst_ena      = !rst && !redirect_valid && (w_credit_used < DEPTH_LIM);
    assign inst_addr     = r_pc;

    assign w_issue = inst_ena && inst_ready;
    // A response with nothing in flight is a protocol violation: ignore it.
    assign w_resp  = inst_rvalid && (r_inflight != '0);
    assign w_drop  = w_resp && (r_drop_cnt != '0);
    assign w_push  = w_resp && !w_drop;
    assign w_pop   = out_valid && out_ready;

    assign w_inflight_after_resp = r_inflight - CW'(w_resp);

    assign out_valid = (r_count != '0);
    assign out_inst  = out_valid ? r_inst_mem[r_rptr] : '0;
    assign out_pc    = out_valid ? r_pc_mem[r_rptr]   : '0;

    // Fetch PC, response PC, FIFO pointers and in-flight/drop accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            // Everything requested so far is stale; drop what is still owed.
            r_pc       <= redirect_pc;
            r_resp_pc  <= redirect_pc;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_inflight <= w_inflight_after_resp;
            r_drop_cnt <= w_inflight_after_resp;
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + PC_INC;
            end
            r_inflight <= r_inflight + CW'(w_issue) - CW'(w_resp);
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            if (w_push) begin
                r_wptr    <= r_wptr + 1'b1;
                r_resp_pc <= r_resp_pc + PC_INC;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // FIFO write port: tag each accepted instruction with its PC
    always_ff @(posedge clk) begin
        if (!rst && w_push && !redirect_valid) begin
            r_inst_mem[r_wptr] <= inst;
            r_pc_mem[r_wptr]   <= r_resp_pc;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed + randomized bench for if_prefetch.
// A memory model answers accepted requests in order (1-cycle minimum
// latency); a scoreboard queue holds {inst, pc} entries expected at the
// decode port, and a pending queue tracks requests the memory still owes.
module tb_if_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct {
        logic [63:0] addr;   // address the DUT actually requested
        logic [63:0] epc;    // address the bench expected it to request
        logic        stale;  // issued before a redirect
        int          due;    // earliest cycle the memory may answer
    } pend_t;

    logic        clk;
    logic        rst;
    logic [63:0] inst_addr;
    logic        inst_ena;
    logic        inst_ready;
    logic [31:0] inst;
    logic        inst_rvalid;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [63:0] out_pc;

    logic [95:0] exp_q[$];   // {inst, pc} expected at decode port
    pend_t       pend[$];    // requests the memory still owes
    logic [63:0] m_pc;
    int          cyc;
    int          issued_cnt;
    int          checks;
    int          errors;
    logic        chk_first;
    logic [63:0] first_target;
    logic [63:0] hold_addr;

    if_prefetch #(
        .ADDR_WIDTH(64),
        .INST_WIDTH(32),
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_addr     (inst_addr),
        .inst_ena      (inst_ena),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_rvalid   (inst_rvalid),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs, advance, update model.
    task automatic cyc_step(input logic rdy, input logic ordy, input logic resp_en,
                            input logic redir, input logic [63:0] rpc);
        logic        have_resp;
        logic        issue;
        logic        pop;
        logic        exp_ena;
        logic [63:0] addr_s;
        pend_t       e;
        have_resp      = resp_en && (pend.size() != 0) && (pend[0].due <= cyc);
        inst_ready     = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        inst_rvalid    = have_resp;
        inst           = have_resp ? mem_data(pend[0].addr) : 32'($urandom);
        #1;
        check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        exp_ena = !redir && ((exp_q.size() + pend.size()) < DEPTH);
        check("inst_ena", 64'(inst_ena), 64'(exp_ena));
        if (inst_ena) check("inst_addr", inst_addr, m_pc);
        pop = ordy && out_valid && (exp_q.size() != 0);
        if (pop) begin
            check("out_pc", out_pc, exp_q[0][63:0]);
            check("out_inst", 64'(out_inst), 64'(exp_q[0][95:64]));
            if (chk_first) begin
                check("first_pc", out_pc, first_target);
                chk_first = 1'b0;
            end
        end
        issue  = inst_ena && inst_ready;
        addr_s = inst_addr;
        @(posedge clk);
        cyc++;
        if (redir) begin
            if (have_resp) void'(pend.pop_front());
            exp_q.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_pc         = rpc;
            chk_first    = 1'b1;
            first_target = rpc;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (have_resp) begin
                e = pend.pop_front();
                if (!e.stale) exp_q.push_back({mem_data(e.epc), e.epc});
            end
            if (issue) begin
                pend.push_back('{addr: addr_s, epc: m_pc, stale: 1'b0, due: cyc});
                m_pc = m_pc + 64'd4;
                issued_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic rdy, input logic ordy, input logic resp_en);
        for (int i = 0; i < n; i++) cyc_step(rdy, ordy, resp_en, 1'b0, 64'd0);
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        m_pc         = RESET_PC;
        chk_first    = 1'b1;
        first_target = RESET_PC;
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; issued_cnt = 0;
        rst = 1'b1; inst_ready = 1'b0; inst = '0; inst_rvalid = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_inst_ena", 64'(inst_ena), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_inst_addr", inst_addr, RESET_PC);
        check("rst_out_inst", 64'(out_inst), 64'd0);
        check("rst_out_pc", out_pc, 64'd0);
        rst = 1'b0;

        // Streaming: one request per cycle, 1-cycle memory
        run(12, 1'b1, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1, 1'b1);

        // Credit limit: out_ready low -> exactly DEPTH requests
        issued_cnt = 0;
        run(8, 1'b1, 1'b0, 1'b1);
        check("credit_issued", 64'(issued_cnt), 64'(DEPTH));
        check("credit_ena_low", 64'(inst_ena), 64'd0);
        run(1, 1'b1, 1'b1, 1'b1);
        run(4, 1'b1, 1'b0, 1'b1);
        check("credit_one_more", 64'(issued_cnt), 64'(DEPTH + 1));
        run(10, 1'b0, 1'b1, 1'b1);

        // inst_ready held low: address stable, nothing happens
        hold_addr = inst_addr;
        for (int i = 0; i < 5; i++) begin
            cyc_step(1'b0, 1'b1, 1'b1, 1'b0, 64'd0);
            check("hold_addr", inst_addr, hold_addr);
        end
        check("hold_no_out", 64'(out_valid), 64'd0);

        // Two requests in flight, then redirect: both responses dropped
        run(2, 1'b1, 1'b1, 1'b0);
        cyc_step(1'b1, 1'b1, 1'b0, 1'b1, 64'h0000_0000_8000_0100);
        run(10, 1'b1, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1, 1'b1);

        // Redirect coinciding with a response and a pop
        run(5, 1'b1, 1'b0, 1'b0);
        run(2, 1'b0, 1'b0, 1'b1);
        cyc_step(1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0200);
        check("redir_flush", 64'(out_valid), 64'd0);
        run(10, 1'b1, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1, 1'b1);

        // Back-to-back redirects (last wins) onto a PC that wraps past 2^64
        run(3, 1'b1, 1'b1, 1'b1);
        cyc_step(1'b1, 1'b1, 1'b1, 1'b1, 64'h0000_0000_8000_0400);
        cyc_step(1'b1, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
        run(8, 1'b1, 1'b1, 1'b1);
        run(8, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset with entries buffered and requests in flight
        run(4, 1'b1, 1'b0, 1'b0);
        run(2, 1'b0, 1'b0, 1'b1);
        inst_ready = 1'b0; inst_rvalid = 1'b0; out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_out_inst", 64'(out_inst), 64'd0);
        check("arst_out_pc", out_pc, 64'd0);
        check("arst_inst_ena", 64'(inst_ena), 64'd0);
        check("arst_inst_addr", inst_addr, RESET_PC);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        // Late responses for pre-reset requests arrive with nothing in flight
        for (int i = 0; i < 2; i++) begin
            inst_ready = 1'b0; out_ready = 1'b1;
            inst_rvalid = 1'b1; inst = 32'($urandom);
            #1;
            check("late_out_valid", 64'(out_valid), 64'd0);
            check("late_inst_ena", 64'(inst_ena), 64'd1);
            check("late_inst_addr", inst_addr, RESET_PC);
            @(posedge clk);
            @(negedge clk);
        end
        inst_rvalid = 1'b0;
        run(10, 1'b1, 1'b1, 1'b1);

        // Randomized traffic with occasional redirects
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0)
                cyc_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b1,
                         64'h0000_0000_9000_0000 + 64'($urandom_range(0, 255) * 4));
            else
                cyc_step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'b0, 64'd0);
        end
        run(12, 1'b0, 1'b1, 1'b1);
        check("end_drained", 64'(out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
